ram_byte_sequencer: RTL and testbench

- Initiator for the byte-masked 64-bit RAM port: address[7:0], spam[2:0], 64-bit data in/out, wren.
- Converts command-driven byte streams into RAM word writes, and RAM word reads back into byte streams.
- Packs 8 bytes per word, little-endian. Drives spam = valid bytes − 1 on the partial final word.
- Sits between the encryption datapath (byte streams) and the RAM wrapper.

---
 rtl/ram_byte_sequencer.sv | 214 +++++++++++++++++++++
 tb/tb_ram_byte_sequencer.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_byte_sequencer.sv
// ram_byte_sequencer
// Bridges byte streams and a byte-masked 64-bit RAM port. Write commands pack
// incoming bytes little-endian into words (byte 0 in bits 7:0) and issue one
// write per word. Read commands fetch words and replay them as a byte stream.
// ram_spam is the highest valid byte index of the word being accessed.
//
// Optional feature: define BYTE_SEQ_WRAP_ERR_EN to reject commands whose word
// span runs past address 255. Such a command sets the sticky o_err and goes
// straight to done without touching the RAM or either stream. Without the
// macro o_err is tied 0 and addresses wrap silently mod 256.
//
// Parameters:
//   RD_LAT          cycles from read address issue to valid i_ram_data_out (1..3)
// Ports:
//   i_clk, i_rst_n  clock (rising edge), synchronous active-low reset
//   i_cmd_*         command request: valid, write/read, start word address, byte length
//   o_cmd_ready     high only while idle
//   i_in_* / o_in_ready          write byte stream
//   o_out_* / i_out_ready        read byte stream, o_out_last marks the final byte
//   o_done          one-cycle pulse when a command completes
//   o_err           sticky wrap error (feature only)
//   o_ram_*         RAM address, byte mask, write data, write enable
//   i_ram_data_out  RAM read data
module ram_byte_sequencer #(
    parameter int unsigned RD_LAT = 1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    input  logic        i_cmd_write,
    input  logic [7:0]  i_cmd_addr,
    input  logic [10:0] i_cmd_len,
    input  logic        i_in_valid,
    output logic        o_in_ready,
    input  logic [7:0]  i_in_byte,
    output logic        o_out_valid,
    input  logic        i_out_ready,
    output logic [7:0]  o_out_byte,
    output logic        o_out_last,
    output logic        o_done,
    output logic        o_err,
    output logic [7:0]  o_ram_address,
    output logic [2:0]  o_ram_spam,
    output logic [63:0] o_ram_data_in,
    output logic        o_ram_wren,
    input  logic [63:0] i_ram_data_out
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_WR_FILL  = 3'd1;
    localparam logic [2:0] S_WR_ISSUE = 3'd2;
    localparam logic [2:0] S_RD_ISSUE = 3'd3;
    localparam logic [2:0] S_RD_WAIT  = 3'd4;
    localparam logic [2:0] S_RD_DRAIN = 3'd5;
    localparam logic [2:0] S_DONE     = 3'd6;

    localparam logic [1:0] LAT_LAST = 2'(RD_LAT - 1);

    logic [2:0]  r_state;
    logic [7:0]  r_addr;
    logic [10:0] r_remain;
    // Fill count when writing, drain index when reading. Eight filled bytes
    // wrap it to 0, so (r_cnt - 1) mod 8 is still the correct spam of 7.
    logic [2:0]  r_cnt;
    logic [63:0] r_buf;
    logic [1:0]  r_lat;

    logic [5:0]  w_sel;
    logic        w_word_end;
    logic [2:0]  w_rd_spam;

    assign w_sel      = {r_cnt, 3'b000};
    // Current word closes on its eighth byte or on the command's final byte.
    assign w_word_end = (r_cnt == 3'd7) || (r_remain == 11'd1);
    assign w_rd_spam  = (r_remain < 11'd8) ? (r_remain[2:0] - 3'd1) : 3'd7;

`ifdef BYTE_SEQ_WRAP_ERR_EN
    logic        r_err;
    logic [11:0] w_words;
    logic [11:0] w_span;
    logic        w_wrap;

    assign w_words = ({1'b0, i_cmd_len} + 12'd7) >> 3;
    assign w_span  = {4'd0, i_cmd_addr} + w_words;
    assign w_wrap  = (w_span > 12'd256);
    assign o_err   = r_err;
`else
    assign o_err   = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state  <= S_IDLE;
            r_addr   <= 8'd0;
            r_remain <= 11'd0;
            r_cnt    <= 3'd0;
            r_buf    <= 64'd0;
            r_lat    <= 2'd0;
`ifdef BYTE_SEQ_WRAP_ERR_EN
            r_err    <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_cmd_valid) begin
                        r_addr   <= i_cmd_addr;
                        r_remain <= i_cmd_len;
                        r_cnt    <= 3'd0;
                        r_buf    <= 64'd0;
                        if (i_cmd_len == 11'd0) begin
                            r_state <= S_DONE;
`ifdef BYTE_SEQ_WRAP_ERR_EN
                        end else if (w_wrap) begin
                            r_err   <= 1'b1;
                            r_state <= S_DONE;
`endif
                        end else if (i_cmd_write) begin
                            r_state <= S_WR_FILL;
                        end else begin
                            r_state <= S_RD_ISSUE;
                        end
                    end
                end

                S_WR_FILL: begin
                    if (i_in_valid && (r_remain != 11'd0)) begin
                        r_buf[w_sel +: 8] <= i_in_byte;
                        r_cnt             <= r_cnt + 3'd1;
                        r_remain          <= r_remain - 11'd1;
                        if (w_word_end) begin
                            r_state <= S_WR_ISSUE;
                        end
                    end
                end

                S_WR_ISSUE: begin
                    r_addr  <= r_addr + 8'd1;
                    r_buf   <= 64'd0;
                    r_cnt   <= 3'd0;
                    r_state <= (r_remain != 11'd0) ? S_WR_FILL : S_DONE;
                end

                S_RD_ISSUE: begin
                    r_lat   <= 2'd0;
                    r_state <= S_RD_WAIT;
                end

                S_RD_WAIT: begin
                    if (r_lat == LAT_LAST) begin
                        r_buf   <= i_ram_data_out;
                        r_cnt   <= 3'd0;
                        r_state <= S_RD_DRAIN;
                    end else begin
                        r_lat <= r_lat + 2'd1;
                    end
                end

                S_RD_DRAIN: begin
                    if (i_out_ready && (r_remain != 11'd0)) begin
                        r_cnt    <= r_cnt + 3'd1;
                        r_remain <= r_remain - 11'd1;
                        if (w_word_end) begin
                            r_addr  <= r_addr + 8'd1;
                            r_state <= (r_remain != 11'd1) ? S_RD_ISSUE : S_DONE;
                        end
                    end
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        o_cmd_ready   = (r_state == S_IDLE);
        o_in_ready    = (r_state == S_WR_FILL);
        o_out_valid   = 1'b0;
        o_out_byte    = 8'd0;
        o_out_last    = 1'b0;
        o_done        = 1'b0;
        o_ram_address = r_addr;
        o_ram_spam    = 3'd0;
        o_ram_data_in = 64'd0;
        o_ram_wren    = 1'b0;
        case (r_state)
            S_WR_ISSUE: begin
                o_ram_wren    = 1'b1;
                o_ram_spam    = r_cnt - 3'd1;
                o_ram_data_in = r_buf;
            end
            S_RD_ISSUE, S_RD_WAIT: begin
                o_ram_spam = w_rd_spam;
            end
            S_RD_DRAIN: begin
                o_out_valid = 1'b1;
                o_out_byte  = r_buf[w_sel +: 8];
                o_out_last  = (r_remain == 11'd1);
            end
            S_DONE: begin
                o_done = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_ram_byte_sequencer.sv
`timescale 1ns/1ps
module tb_ram_byte_sequencer;

    localparam int RD_LAT = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [7:0]  cmd_addr;
    logic [10:0] cmd_len;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_byte;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_byte;
    logic        out_last;
    logic        done;
    logic        err;
    logic [7:0]  ram_address;
    logic [2:0]  ram_spam;
    logic [63:0] ram_data_in;
    logic        ram_wren;
    logic [63:0] ram_data_out;

    always #5 clk = ~clk;

    ram_byte_sequencer #(.RD_LAT(RD_LAT)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_cmd_valid    (cmd_valid),
        .o_cmd_ready    (cmd_ready),
        .i_cmd_write    (cmd_write),
        .i_cmd_addr     (cmd_addr),
        .i_cmd_len      (cmd_len),
        .i_in_valid     (in_valid),
        .o_in_ready     (in_ready),
        .i_in_byte      (in_byte),
        .o_out_valid    (out_valid),
        .i_out_ready    (out_ready),
        .o_out_byte     (out_byte),
        .o_out_last     (out_last),
        .o_done         (done),
        .o_err          (err),
        .o_ram_address  (ram_address),
        .o_ram_spam     (ram_spam),
        .o_ram_data_in  (ram_data_in),
        .o_ram_wren     (ram_wren),
        .i_ram_data_out (ram_data_out)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // RAM model: byte-masked write, RD_LAT-cycle read pipeline.
    bit [63:0]   ram_mem [256];
    bit [63:0]   model_mem [256];
    bit [63:0]   rd_pipe [RD_LAT];
    logic [7:0]  rd_addr_s = 8'd0;
    int          cyc = 0;
    int          wr_cnt = 0;
    int          done_cnt = 0;
    int          last_wr_cyc = 0;
    int          last_done_cyc = 0;
    logic [7:0]  wr_addr_q[$];
    logic [2:0]  wr_spam_q[$];
    logic [63:0] wr_data_q[$];
    logic [7:0]  wbytes[$];

    assign ram_data_out = rd_pipe[RD_LAT-1];

    function automatic logic [63:0] merge(input logic [63:0] old_w, input logic [63:0] new_w,
                                          input logic [2:0] spam);
        logic [63:0] r;
        r = old_w;
        for (int b = 0; b <= int'(spam); b++) r[8*b +: 8] = new_w[8*b +: 8];
        return r;
    endfunction

    always @(negedge clk) begin
        cyc       <= cyc + 1;
        rd_addr_s <= ram_address;
        if (ram_wren === 1'b1) begin
            ram_mem[ram_address] <= merge(ram_mem[ram_address], ram_data_in, ram_spam);
            wr_addr_q.push_back(ram_address);
            wr_spam_q.push_back(ram_spam);
            wr_data_q.push_back(ram_data_in);
            wr_cnt      <= wr_cnt + 1;
            last_wr_cyc <= cyc;
        end
        if (done === 1'b1) begin
            done_cnt      <= done_cnt + 1;
            last_done_cyc <= cyc;
        end
    end

    always @(posedge clk) begin
        rd_pipe[0] <= ram_mem[rd_addr_s];
        for (int k = 1; k < RD_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [7:0] exp_byte(input logic [7:0] a, input int i);
        logic [63:0] wd;
        wd = model_mem[8'(int'(a) + i / 8)];
        return wd[8*(i % 8) +: 8];
    endfunction

    // Write wbytes[0..len-1] starting at word a; in_valid dropped gap% of cycles.
    task automatic do_write(input logic [7:0] a, input int len, input int gap);
        int idx, t, d0, nw, n;
        logic [63:0] exp_data;
        wr_addr_q.delete();
        wr_spam_q.delete();
        wr_data_q.delete();
        d0 = done_cnt;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = a;
        cmd_len   = 11'(len);
        check("wr_cmd_ready", 64'(cmd_ready), 64'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        idx = 0;
        t   = 0;
        while (idx < len && t < 4000) begin
            in_valid = ($urandom_range(99) >= gap);
            in_byte  = wbytes[idx];
            if (in_valid && in_ready) idx++;
            @(negedge clk);
            t++;
        end
        in_valid = 1'b0;
        check("wr_feed_complete", 64'(idx), 64'(len));
        t = 0;
        while (done_cnt == d0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        repeat (2) @(negedge clk);
        check("wr_done_once", 64'(done_cnt - d0), 64'd1);
        if (len > 0) check("wr_done_lat", 64'(last_done_cyc), 64'(last_wr_cyc + 1));
        nw = (len + 7) / 8;
        check("wr_count", 64'(wr_addr_q.size()), 64'(nw));
        for (int w = 0; w < nw && w < wr_addr_q.size(); w++) begin
            n = imin(8, len - 8 * w);
            exp_data = 64'd0;
            for (int b = 0; b < n; b++) exp_data[8*b +: 8] = wbytes[8*w + b];
            check("wr_addr", 64'(wr_addr_q[w]), 64'((int'(a) + w) % 256));
            check("wr_spam", 64'(wr_spam_q[w]), 64'(n - 1));
            check("wr_data", wr_data_q[w], exp_data);
        end
        for (int i = 0; i < len; i++) model_mem[8'(int'(a) + i / 8)][8*(i % 8) +: 8] = wbytes[i];
    endtask

    // Read len bytes from word a. mode 0: always ready, 1: toggling, 2: random.
    task automatic do_read(input logic [7:0] a, input int len, input int mode);
        int i, t, d0, w;
        logic       stalled;
        logic [7:0] prev_byte;
        i = 0;
        t = 0;
        stalled = 1'b0;
        prev_byte = 8'd0;
        d0 = done_cnt;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = a;
        cmd_len   = 11'(len);
        check("rd_cmd_ready", 64'(cmd_ready), 64'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        while (i < len && t < 4000) begin
            out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? t[0] : 1'($urandom_range(1));
            w = i / 8;
            if (out_valid) begin
                if (stalled) check("rd_hold", 64'(out_byte), 64'(prev_byte));
                check("rd_drain_addr", 64'(ram_address), 64'((int'(a) + w) % 256));
                if (out_ready) begin
                    check("rd_byte", 64'(out_byte), 64'(exp_byte(a, i)));
                    check("rd_last", 64'(out_last), 64'(i == len - 1));
                    i++;
                    stalled = 1'b0;
                end else begin
                    stalled   = 1'b1;
                    prev_byte = out_byte;
                end
            end else if (!done) begin
                stalled = 1'b0;
                check("rd_issue_addr", 64'(ram_address), 64'((int'(a) + w) % 256));
                check("rd_spam", 64'(ram_spam), 64'(imin(8, len - 8 * w) - 1));
                check("rd_no_wren", 64'(ram_wren), 64'd0);
            end
            @(negedge clk);
            t++;
        end
        out_ready = 1'b0;
        check("rd_complete", 64'(i), 64'(len));
        t = 0;
        while (done_cnt == d0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        repeat (2) @(negedge clk);
        check("rd_done_once", 64'(done_cnt - d0), 64'd1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int wr0, d0, len;
        logic [7:0] a;
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr = 8'd0;
        cmd_len = 11'd0;
        in_valid = 1'b0;
        in_byte = 8'd0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_byte", 64'(out_byte), 64'd0);
        check("rst_out_last", 64'(out_last), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_ram_address", 64'(ram_address), 64'd0);
        check("rst_ram_spam", 64'(ram_spam), 64'd0);
        check("rst_ram_data_in", ram_data_in, 64'd0);
        check("rst_ram_wren", 64'(ram_wren), 64'd0);
        rst_n = 1'b1;

        // Full word.
        wbytes = {8'hFF, 8'hDE, 8'hBA, 8'h9A, 8'h78, 8'h00, 8'h34, 8'hE2};
        do_write(8'h00, 8, 0);
        check("wr_full_word_const", model_mem[0], 64'hE23400789ABADEFF);
        // Partial word.
        wbytes = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        do_write(8'h01, 6, 0);
        // Two words, second partial, with input gaps.
        wbytes.delete();
        for (int i = 0; i < 12; i++) wbytes.push_back(8'($urandom));
        do_write(8'h10, 12, 40);
        // Set word 1 for the read tests.
        wbytes = {8'h88, 8'h77, 8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11};
        do_write(8'h01, 8, 0);
        check("ram_word1_const", model_mem[1], 64'h1122334455667788);
        do_read(8'h00, 10, 0);
        do_read(8'h00, 10, 1);
        // Zero-length commands are no-ops that still pulse done.
        wr0 = wr_cnt;
        do_write(8'h40, 0, 0);
        do_read(8'h40, 0, 0);
        check("len0_no_wren", 64'(wr_cnt - wr0), 64'd0);

        for (int r = 0; r < 10; r++) begin
            a   = 8'($urandom_range(200));
            len = $urandom_range(40, 1);
            wbytes.delete();
            for (int i = 0; i < len; i++) wbytes.push_back(8'($urandom));
            do_write(a, len, 30);
            do_read(a, len, 2);
        end

`ifdef BYTE_SEQ_WRAP_ERR_EN
        wr0 = wr_cnt;
        d0  = done_cnt;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 8'hFF;
        cmd_len   = 11'd16;
        @(negedge clk);
        cmd_valid = 1'b0;
        in_valid  = 1'b1;
        repeat (5) @(negedge clk);
        in_valid  = 1'b0;
        check("wrap_err", 64'(err), 64'd1);
        check("wrap_no_wren", 64'(wr_cnt - wr0), 64'd0);
        check("wrap_done", 64'(done_cnt - d0), 64'd1);
        repeat (3) @(negedge clk);
        check("wrap_err_sticky", 64'(err), 64'd1);
`else
        wbytes.delete();
        for (int i = 0; i < 16; i++) wbytes.push_back(8'($urandom));
        do_write(8'hFF, 16, 0);
        do_read(8'hFF, 16, 1);
        check("wrap_err_tied", 64'(err), 64'd0);
`endif

        // Reset in the middle of a write fill.
        wr0 = wr_cnt;
        d0  = done_cnt;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 8'h20;
        cmd_len   = 11'd16;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_byte  = 8'(8'hA0 + i);
            check("mid_in_ready", 64'(in_ready), 64'd1);
            @(negedge clk);
        end
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("mid_rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check("mid_rst_in_ready", 64'(in_ready), 64'd0);
        check("mid_rst_err", 64'(err), 64'd0);
        check("mid_rst_ram_address", 64'(ram_address), 64'd0);
        repeat (4) @(negedge clk);
        check("mid_rst_no_wren", 64'(wr_cnt - wr0), 64'd0);
        check("mid_rst_no_done", 64'(done_cnt - d0), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
